cicero_cmd_ctrl: RTL and testbench

CICERO_CMD_CTRL -- requirements
Module: cicero_cmd_ctrl

---
 rtl/cicero_cmd_ctrl.sv | 247 ++++++++++++++++++++++++
 tb/tb_cicero_cmd_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cicero_cmd_ctrl.sv
// cicero_cmd_ctrl: register-side command decoder and sequencer for the
// CICERO core. Accepts one command per cycle, drives the instruction-memory
// strobes and core start/soft-reset pulses, and reports a status word.
// Optional feature macro: CICERO_CMD_CTRL_PERF_COUNTERS_EN enables the
// elapsed-cycle counter and the cache hit/miss readback paths.
module cicero_cmd_ctrl #(
   parameter int REG_WIDTH      = 32,
   parameter int MEM_ADDR_WIDTH = 10
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      cmd_valid,
   input  logic [REG_WIDTH-1:0]      cmd,
   input  logic [REG_WIDTH-1:0]      cmd_addr,
   input  logic [REG_WIDTH-1:0]      cmd_data,
   output logic                      cmd_ready,
   output logic [REG_WIDTH-1:0]      status,
   output logic [REG_WIDTH-1:0]      rd_data,
   output logic                      mem_we,
   output logic                      mem_re,
   output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
   output logic [REG_WIDTH-1:0]      mem_wdata,
   input  logic [REG_WIDTH-1:0]      mem_rdata,
   output logic                      core_start,
   output logic                      core_soft_rst,
   input  logic                      core_done,
   input  logic                      core_accept,
   input  logic [REG_WIDTH-1:0]      fifo_count,
   input  logic [REG_WIDTH-1:0]      cache_hits,
   input  logic [REG_WIDTH-1:0]      cache_miss
);

   localparam logic [REG_WIDTH-1:0] CMD_NOP          = REG_WIDTH'(0);
   localparam logic [REG_WIDTH-1:0] CMD_WRITE        = REG_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0] CMD_READ         = REG_WIDTH'(2);
   localparam logic [REG_WIDTH-1:0] CMD_START        = REG_WIDTH'(3);
   localparam logic [REG_WIDTH-1:0] CMD_RESET        = REG_WIDTH'(4);
   localparam logic [REG_WIDTH-1:0] CMD_RD_ELAPSED   = REG_WIDTH'(5);
   localparam logic [REG_WIDTH-1:0] CMD_RESTART      = REG_WIDTH'(6);
   localparam logic [REG_WIDTH-1:0] CMD_RD_FIFO      = REG_WIDTH'(7);
   localparam logic [REG_WIDTH-1:0] CMD_RD_HITS      = REG_WIDTH'(8);
   localparam logic [REG_WIDTH-1:0] CMD_RD_MISS      = REG_WIDTH'(9);

   localparam logic [REG_WIDTH-1:0] STAT_IDLE        = REG_WIDTH'(0);
   localparam logic [REG_WIDTH-1:0] STAT_RUNNING     = REG_WIDTH'(1);
   localparam logic [REG_WIDTH-1:0] STAT_ACCEPTED    = REG_WIDTH'(2);
   localparam logic [REG_WIDTH-1:0] STAT_REJECTED    = REG_WIDTH'(3);
   localparam logic [REG_WIDTH-1:0] STAT_ERROR       = REG_WIDTH'(4);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_WAIT,
      ST_RUNNING,
      ST_DONE_ACC,
      ST_DONE_REJ,
      ST_ERR
   } state_t;

   state_t                      state_reg, state_next;
   state_t                      ret_state_reg, ret_state_next;
   logic                        rd_cap_reg, rd_cap_next;
   logic [REG_WIDTH-1:0]        rd_data_reg, rd_data_next;
   logic                        mem_we_reg, mem_we_next;
   logic                        mem_re_reg, mem_re_next;
   logic [MEM_ADDR_WIDTH-1:0]   mem_addr_reg, mem_addr_next;
   logic [REG_WIDTH-1:0]        mem_wdata_reg, mem_wdata_next;
   logic                        core_start_reg, core_start_next;
   logic                        core_soft_rst_reg, core_soft_rst_next;
   logic                        clr_elapsed;

   logic                        accept;
   logic                        running;
   logic                        addr_oob;
   logic                        restart_ok;
   logic [REG_WIDTH-1:0]        elapsed_val;
   logic [REG_WIDTH-1:0]        hits_val;
   logic [REG_WIDTH-1:0]        miss_val;

   assign accept     = cmd_valid && (state_reg != ST_RD_WAIT);
   assign running    = (state_reg == ST_RUNNING);
   assign addr_oob   = |cmd_addr[REG_WIDTH-1:MEM_ADDR_WIDTH];
   assign restart_ok = (state_reg == ST_DONE_ACC) || (state_reg == ST_DONE_REJ);

`ifdef CICERO_CMD_CTRL_PERF_COUNTERS_EN
   logic [REG_WIDTH-1:0] elapsed_reg, elapsed_next;

   // Elapsed counter: cleared on start/reset, counts RUNNING cycles, saturates.
   always_comb begin
      elapsed_next = elapsed_reg;
      if (clr_elapsed)
         elapsed_next = '0;
      else if (running && (elapsed_reg != '1))
         elapsed_next = elapsed_reg + REG_WIDTH'(1);
   end

   // Elapsed counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         elapsed_reg <= '0;
      else
         elapsed_reg <= elapsed_next;
   end

   assign elapsed_val = elapsed_reg;
   assign hits_val    = cache_hits;
   assign miss_val    = cache_miss;
`else
   logic unused_perf;

   // Without the perf feature the counter readbacks return zero.
   assign elapsed_val = '0;
   assign hits_val    = '0;
   assign miss_val    = '0;
   assign unused_perf = ^{cache_hits, cache_miss, clr_elapsed};
`endif

   // Next-state and next-output decode; a pending read capture is the default
   // rd_data update and any rd_data-loading command accepted alongside wins.
   always_comb begin
      state_next         = state_reg;
      ret_state_next     = ret_state_reg;
      rd_cap_next        = 1'b0;
      rd_data_next       = rd_cap_reg ? mem_rdata : rd_data_reg;
      mem_we_next        = 1'b0;
      mem_re_next        = 1'b0;
      mem_addr_next      = mem_addr_reg;
      mem_wdata_next     = mem_wdata_reg;
      core_start_next    = 1'b0;
      core_soft_rst_next = 1'b0;
      clr_elapsed        = 1'b0;

      if (state_reg == ST_RD_WAIT) begin
         state_next  = ret_state_reg;
         rd_cap_next = 1'b1;
      end else if (running && core_done) begin
         state_next = core_accept ? ST_DONE_ACC : ST_DONE_REJ;
      end

      if (accept) begin
         case (cmd)
            CMD_NOP: begin
            end
            CMD_WRITE: begin
               if (!running) begin
                  if (addr_oob) begin
                     state_next = ST_ERR;
                  end else begin
                     mem_we_next    = 1'b1;
                     mem_addr_next  = cmd_addr[MEM_ADDR_WIDTH-1:0];
                     mem_wdata_next = cmd_data;
                  end
               end
            end
            CMD_READ: begin
               if (!running) begin
                  if (addr_oob) begin
                     state_next = ST_ERR;
                  end else begin
                     mem_re_next    = 1'b1;
                     mem_addr_next  = cmd_addr[MEM_ADDR_WIDTH-1:0];
                     ret_state_next = state_reg;
                     state_next     = ST_RD_WAIT;
                  end
               end
            end
            CMD_START: begin
               if (!running) begin
                  core_start_next = 1'b1;
                  clr_elapsed     = 1'b1;
                  state_next      = ST_RUNNING;
               end
            end
            CMD_RESTART: begin
               if (restart_ok) begin
                  core_start_next = 1'b1;
                  clr_elapsed     = 1'b1;
                  state_next      = ST_RUNNING;
               end else if (!running) begin
                  state_next = ST_ERR;
               end
            end
            CMD_RESET: begin
               core_soft_rst_next = 1'b1;
               clr_elapsed        = 1'b1;
               rd_data_next       = '0;
               state_next         = ST_IDLE;
            end
            CMD_RD_ELAPSED: rd_data_next = elapsed_val;
            CMD_RD_FIFO:    rd_data_next = fifo_count;
            CMD_RD_HITS:    rd_data_next = hits_val;
            CMD_RD_MISS:    rd_data_next = miss_val;
            default:        state_next   = ST_ERR;
         endcase
      end
   end

   // State and registered-output update; async reset abandons any operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= ST_IDLE;
         ret_state_reg     <= ST_IDLE;
         rd_cap_reg        <= 1'b0;
         rd_data_reg       <= '0;
         mem_we_reg        <= 1'b0;
         mem_re_reg        <= 1'b0;
         mem_addr_reg      <= '0;
         mem_wdata_reg     <= '0;
         core_start_reg    <= 1'b0;
         core_soft_rst_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         ret_state_reg     <= ret_state_next;
         rd_cap_reg        <= rd_cap_next;
         rd_data_reg       <= rd_data_next;
         mem_we_reg        <= mem_we_next;
         mem_re_reg        <= mem_re_next;
         mem_addr_reg      <= mem_addr_next;
         mem_wdata_reg     <= mem_wdata_next;
         core_start_reg    <= core_start_next;
         core_soft_rst_reg <= core_soft_rst_next;
      end
   end

   // Status word mirrors the state; a read in flight reports IDLE.
   always_comb begin
      status = STAT_IDLE;
      case (state_reg)
         ST_IDLE:     status = STAT_IDLE;
         ST_RD_WAIT:  status = STAT_IDLE;
         ST_RUNNING:  status = STAT_RUNNING;
         ST_DONE_ACC: status = STAT_ACCEPTED;
         ST_DONE_REJ: status = STAT_REJECTED;
         ST_ERR:      status = STAT_ERROR;
         default:     status = STAT_ERROR;
      endcase
   end

   assign cmd_ready     = (state_reg != ST_RD_WAIT);
   assign rd_data       = rd_data_reg;
   assign mem_we        = mem_we_reg;
   assign mem_re        = mem_re_reg;
   assign mem_addr      = mem_addr_reg;
   assign mem_wdata     = mem_wdata_reg;
   assign core_start    = core_start_reg;
   assign core_soft_rst = core_soft_rst_reg;

endmodule

// File: tb/tb_cicero_cmd_ctrl.sv
// tb_cicero_cmd_ctrl: directed scenarios plus randomized traffic for
// cicero_cmd_ctrl, checked every cycle against a transaction-level model.
// Honours CICERO_CMD_CTRL_PERF_COUNTERS_EN for the expected counter readbacks.
module tb_cicero_cmd_ctrl;

`ifdef CICERO_CMD_CTRL_PERF_COUNTERS_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic [31:0] cmd;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_data;
   logic        cmd_ready;
   logic [31:0] status;
   logic [31:0] rd_data;
   logic        mem_we;
   logic        mem_re;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        core_start;
   logic        core_soft_rst;
   logic        core_done;
   logic        core_accept;
   logic [31:0] fifo_count;
   logic [31:0] cache_hits;
   logic [31:0] cache_miss;

   int n_vec  = 0;
   int n_miss = 0;

   cicero_cmd_ctrl #(.REG_WIDTH(32), .MEM_ADDR_WIDTH(10)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd(cmd), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .cmd_ready(cmd_ready), .status(status), .rd_data(rd_data),
      .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .core_start(core_start), .core_soft_rst(core_soft_rst),
      .core_done(core_done), .core_accept(core_accept),
      .fifo_count(fifo_count), .cache_hits(cache_hits), .cache_miss(cache_miss)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous instruction memory: data appears the cycle after mem_re,
   // garbage otherwise so a mistimed capture is visible.
   bit [31:0] bmem [0:1023];
   always @(posedge clk) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= bmem[mem_addr];
      else        mem_rdata <= $urandom;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Status codes: 0 idle, 1 running, 2 accepted, 3 rejected, 4 error.
   bit [31:0]   m_mem [0:1023];
   int unsigned m_st      = 0;
   bit          m_rdwait  = 0;   // the cycle after a READ is accepted
   bit          m_rdcap   = 0;   // data lands on the following edge
   int unsigned m_rdaddr  = 0;
   logic [31:0] m_el      = 0;
   logic [31:0] e_rd      = 0;
   bit          e_we = 0, e_re = 0, e_start = 0, e_srst = 0;
   logic [31:0] e_addr    = 0;
   logic [31:0] e_wdata   = 0;

   task automatic model_step();
      bit          ready0;
      bit          run0;
      bit          oob;
      logic [31:0] el0;
      if (!rst_n) begin
         m_st = 0; m_rdwait = 0; m_rdcap = 0; m_el = 0; e_rd = 0;
         e_we = 0; e_re = 0; e_start = 0; e_srst = 0; e_addr = 0; e_wdata = 0;
         return;
      end
      ready0  = !m_rdwait;
      run0    = (m_st == 1) && ready0;
      el0     = m_el;
      e_we = 0; e_re = 0; e_start = 0; e_srst = 0;
      if (m_rdcap) begin
         e_rd    = m_mem[m_rdaddr];
         m_rdcap = 0;
      end
      if (m_rdwait) begin
         m_rdwait = 0;
         m_rdcap  = 1;
      end
      if (run0) begin
         if (m_el != 32'hFFFF_FFFF) m_el = m_el + 1;
         if (core_done) m_st = core_accept ? 2 : 3;
      end
      if (cmd_valid && ready0) begin
         oob = (cmd_addr >= 32'd1024);
         if (cmd == 4) begin
            e_srst = 1; m_el = 0; e_rd = 0; m_st = 0;
         end else if (cmd > 9) begin
            m_st = 4;
         end else if (cmd == 7) begin
            e_rd = fifo_count;
         end else if (cmd == 5) begin
            e_rd = PERF ? el0 : 32'd0;
         end else if (cmd == 8) begin
            e_rd = PERF ? cache_hits : 32'd0;
         end else if (cmd == 9) begin
            e_rd = PERF ? cache_miss : 32'd0;
         end else if (cmd != 0 && !run0) begin
            if (cmd == 1 || cmd == 2) begin
               if (oob) m_st = 4;
               else if (cmd == 1) begin
                  e_we = 1; e_addr = cmd_addr; e_wdata = cmd_data;
                  m_mem[cmd_addr[9:0]] = cmd_data;
               end else begin
                  e_re = 1; e_addr = cmd_addr; m_rdwait = 1; m_rdaddr = cmd_addr[9:0];
               end
            end else if (cmd == 3 || (cmd == 6 && (m_st == 2 || m_st == 3))) begin
               e_start = 1; m_el = 0; m_st = 1;
            end else if (cmd == 6) begin
               m_st = 4;
            end
         end
      end
   endtask

   // Per-cycle compare against the model, shortly after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("cyc_status",    status,        m_rdwait ? 32'd0 : 32'(m_st));
         chk("cyc_cmd_ready", {31'd0, cmd_ready}, {31'd0, !m_rdwait});
         chk("cyc_rd_data",   rd_data,       e_rd);
         chk("cyc_mem_we",    {31'd0, mem_we},        {31'd0, e_we});
         chk("cyc_mem_re",    {31'd0, mem_re},        {31'd0, e_re});
         chk("cyc_core_start",{31'd0, core_start},    {31'd0, e_start});
         chk("cyc_soft_rst",  {31'd0, core_soft_rst}, {31'd0, e_srst});
         if (e_we || e_re || !rst_n)
            chk("cyc_mem_addr", {22'd0, mem_addr}, e_addr);
         if (e_we || !rst_n)
            chk("cyc_mem_wdata", mem_wdata, e_wdata);
      end
   end

   // Apply one command for one cycle, starting and ending on a falling edge.
   task automatic send(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d);
      $display("txn t=%0t cmd=%0d addr=%0h data=%0h", $time, c, a, d);
      cmd_valid = 1'b1; cmd = c; cmd_addr = a; cmd_data = d;
      @(negedge clk);
      cmd_valid = 1'b0; cmd = 32'd0; cmd_addr = 32'd0; cmd_data = 32'd0;
   endtask

   initial begin
      int r;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd = 0; cmd_addr = 0; cmd_data = 0;
      core_done = 1'b0; core_accept = 1'b0; fifo_count = 0;
      cache_hits = 32'h11; cache_miss = 32'h22;
      repeat (3) @(negedge clk);
      chk("rst_status",   status, 32'd0);
      chk("rst_ready",    {31'd0, cmd_ready}, 32'd1);
      chk("rst_rd_data",  rd_data, 32'd0);
      chk("rst_strobes",  {28'd0, mem_we, mem_re, core_start, core_soft_rst}, 32'd0);
      chk("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Write then read back through the memory.
      send(1, 5, 32'hDEAD_BEEF);
      chk("wr_we_pulse", {31'd0, mem_we}, 32'd1);
      chk("wr_addr",     {22'd0, mem_addr}, 32'd5);
      chk("wr_wdata",    mem_wdata, 32'hDEAD_BEEF);
      send(2, 5, 0);
      chk("wr_we_once",  {31'd0, mem_we}, 32'd0);
      chk("rd_ready_lo", {31'd0, cmd_ready}, 32'd0);
      chk("rd_re_pulse", {31'd0, mem_re}, 32'd1);
      @(negedge clk);
      chk("rd_ready_hi", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      chk("rd_data_beef", rd_data, 32'hDEAD_BEEF);

      // Run for 20 cycles and finish accepted.
      send(3, 0, 0);
      chk("start_pulse", {31'd0, core_start}, 32'd1);
      chk("start_stat",  status, 32'd1);
      repeat (19) @(negedge clk);
      core_done = 1'b1; core_accept = 1'b1;
      @(negedge clk);
      core_done = 1'b0; core_accept = 1'b0;
      chk("done_acc", status, 32'd2);
      send(5, 0, 0);
      chk("elapsed_20", rd_data, PERF ? 32'd20 : 32'd0);
      send(8, 0, 0);
      chk("cache_hits", rd_data, PERF ? 32'h11 : 32'd0);
      chk("rd_cmd_keeps_state", status, 32'd2);

      // RESET in the same cycle as core_done.
      send(3, 0, 0);
      repeat (3) @(negedge clk);
      core_done = 1'b1; core_accept = 1'b1;
      send(4, 0, 0);
      core_done = 1'b0; core_accept = 1'b0;
      chk("rst_cmd_srst", {31'd0, core_soft_rst}, 32'd1);
      chk("rst_cmd_stat", status, 32'd0);
      @(negedge clk);
      chk("rst_cmd_srst_once", {31'd0, core_soft_rst}, 32'd0);
      chk("rst_cmd_stat2", status, 32'd0);

      // Out-of-range write, then START recovers.
      send(1, 1024, 32'h1);
      chk("oob_no_we", {31'd0, mem_we}, 32'd0);
      chk("oob_err",   status, 32'd4);
      send(3, 0, 0);
      chk("err_start", status, 32'd1);
      core_done = 1'b1; core_accept = 1'b0;
      @(negedge clk);
      core_done = 1'b0;
      chk("done_rej", status, 32'd3);

      // RESTART legality.
      send(4, 0, 0);
      send(6, 0, 0);
      chk("restart_idle_err", status, 32'd4);
      send(3, 0, 0);
      core_done = 1'b1; core_accept = 1'b0;
      @(negedge clk);
      core_done = 1'b0;
      send(6, 0, 0);
      chk("restart_pulse", {31'd0, core_start}, 32'd1);
      chk("restart_stat",  status, 32'd1);
      send(4, 0, 0);

      // Unknown code, then async reset during a read.
      send(32'h0A, 0, 0);
      chk("unknown_err", status, 32'd4);
      fifo_count = 32'h1234;
      send(7, 0, 0);
      chk("fifo_count", rd_data, 32'h1234);
      send(2, 7, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_stat",  status, 32'd0);
      chk("async_ready", {31'd0, cmd_ready}, 32'd1);
      chk("async_rd",    rd_data, 32'd0);
      chk("async_re",    {31'd0, mem_re}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic, model-checked every cycle.
      for (int i = 0; i < 600; i++) begin
         rst_n     = ($urandom_range(0, 199) != 0);
         cmd_valid = $urandom_range(0, 1);
         r = $urandom_range(0, 99);
         if (r < 88) begin
            cmd = $urandom_range(0, 9);
            if (cmd == 4 && $urandom_range(0, 2) != 0) cmd = 3;
         end else if (r < 96) cmd = $urandom_range(10, 15);
         else cmd = $urandom;
         r = $urandom_range(0, 99);
         if (r < 80)      cmd_addr = $urandom_range(0, 15);
         else if (r < 90) cmd_addr = $urandom_range(1023, 1024);
         else             cmd_addr = $urandom;
         cmd_data    = $urandom;
         core_done   = ($urandom_range(0, 9) == 0);
         core_accept = $urandom_range(0, 1);
         fifo_count  = $urandom;
         cache_hits  = $urandom;
         cache_miss  = $urandom;
         if (cmd_valid)
            $display("txn t=%0t cmd=%0h addr=%0h data=%0h rst_n=%0b", $time, cmd, cmd_addr, cmd_data, rst_n);
         @(negedge clk);
      end
      rst_n = 1'b1; cmd_valid = 1'b0; core_done = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
